// File: rtl/prescaler_ext.sv
// Timer prescaler: divides clk_i cycles or synchronised etr_i edges by (shadow+1),
// with counter enable, preload/immediate divisor reload and status readback.
module prescaler_ext #(
    parameter int unsigned PSC_WIDTH   = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 aresetn_i,
    input  logic                 cen_i,
    input  logic                 uev_i,
    input  logic [PSC_WIDTH-1:0] psc_i,
    input  logic                 ppe_i,
    input  logic                 src_sel_i,
    input  logic                 etr_i,
    input  logic                 etr_pol_i,
    output logic                 tick_o,
    output logic [PSC_WIDTH-1:0] cnt_o,
    output logic [PSC_WIDTH-1:0] psc_shadow_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   etr_d_q;
    logic                   etr_s;
    logic                   etr_edge;
    logic                   inc_en;
    logic                   wrap;
    logic [PSC_WIDTH-1:0]   cnt_q;
    logic [PSC_WIDTH-1:0]   cnt_d;
    logic [PSC_WIDTH-1:0]   shadow_q;
    logic [PSC_WIDTH-1:0]   shadow_d;

    // etr_i synchroniser plus edge-detect flop; runs independently of cen_i/src_sel_i
    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            sync_q  <= '0;
            etr_d_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], etr_i};
            etr_d_q <= etr_s;
        end
    end

    assign etr_s    = sync_q[SYNC_STAGES-1];
    assign etr_edge = etr_pol_i ? (~etr_s & etr_d_q) : (etr_s & ~etr_d_q);
    assign inc_en   = cen_i & (src_sel_i ? etr_edge : 1'b1);

    // >= so a divisor shrunk below the running count wraps at once
    assign wrap     = (cnt_q >= shadow_q);
    assign tick_o   = aresetn_i & ~uev_i & inc_en & wrap;

    // Next count: update event beats wrap beats increment
    always_comb begin
        cnt_d = cnt_q;
        if (uev_i) begin
            cnt_d = '0;
        end else if (inc_en && wrap) begin
            cnt_d = '0;
        end else if (inc_en) begin
            cnt_d = cnt_q + PSC_WIDTH'(1);
        end
    end

    always_comb begin
        shadow_d = shadow_q;
        if (!ppe_i || uev_i) begin
            shadow_d = psc_i;
        end
    end

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            cnt_q    <= '0;
            shadow_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
        end
    end

    assign cnt_o        = cnt_q;
    assign psc_shadow_o = shadow_q;

endmodule

// File: tb/tb_prescaler_ext.sv
// Directed bench for prescaler_ext: vector table for the internal-clock path,
// hand sequences for external edges and mid-count reset.
module tb_prescaler_ext;

    localparam int unsigned PSC_WIDTH   = 16;
    localparam int unsigned SYNC_STAGES = 2;

    logic                 clk_i = 1'b0;
    logic                 aresetn_i;
    logic                 cen_i;
    logic                 uev_i;
    logic [PSC_WIDTH-1:0] psc_i;
    logic                 ppe_i;
    logic                 src_sel_i;
    logic                 etr_i;
    logic                 etr_pol_i;
    logic                 tick_o;
    logic [PSC_WIDTH-1:0] cnt_o;
    logic [PSC_WIDTH-1:0] psc_shadow_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic                 cen;
        logic                 uev;
        logic [PSC_WIDTH-1:0] psc;
        logic                 ppe;
        logic                 tick;
        logic [PSC_WIDTH-1:0] cnt;
        logic [PSC_WIDTH-1:0] sh;
    } vec_t;

    vec_t vecs[$];

    prescaler_ext #(
        .PSC_WIDTH   (PSC_WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk_i        (clk_i),
        .aresetn_i    (aresetn_i),
        .cen_i        (cen_i),
        .uev_i        (uev_i),
        .psc_i        (psc_i),
        .ppe_i        (ppe_i),
        .src_sel_i    (src_sel_i),
        .etr_i        (etr_i),
        .etr_pol_i    (etr_pol_i),
        .tick_o       (tick_o),
        .cnt_o        (cnt_o),
        .psc_shadow_o (psc_shadow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic cen, input logic uev, input int psc, input logic ppe,
                       input logic tick, input int cnt, input int sh);
        vec_t v;
        v.cen  = cen;
        v.uev  = uev;
        v.psc  = PSC_WIDTH'(psc);
        v.ppe  = ppe;
        v.tick = tick;
        v.cnt  = PSC_WIDTH'(cnt);
        v.sh   = PSC_WIDTH'(sh);
        vecs.push_back(v);
    endtask

    // Check the current cycle at the falling edge, then advance past the next rising edge
    task automatic cyc(input string nm, input logic tick, input int cnt, input int sh);
        @(negedge clk_i);
        chk({nm, ".tick"}, 32'(tick_o), 32'(tick));
        chk({nm, ".cnt"}, 32'(cnt_o), 32'(cnt));
        chk({nm, ".sh"}, 32'(psc_shadow_o), 32'(sh));
        @(posedge clk_i);
        #1;
    endtask

    // External square wave, period 8; off is the step where the counted edge reaches the counter
    task automatic run_etr(input string nm, input int off);
        int ev_before;
        logic exp_tick;
        for (int k = 0; k < 32; k++) begin
            etr_i     = ((k % 8) < 4);
            ev_before = (k > off) ? ((k - off - 1) / 8 + 1) : 0;
            exp_tick  = (k >= off) && ((k - off) % 8 == 0) && ((((k - off) / 8) % 2) == 1);
            @(negedge clk_i);
            chk({nm, ".tick"}, 32'(tick_o), 32'(exp_tick));
            chk({nm, ".cnt"}, 32'(cnt_o), 32'(ev_before % 2));
            @(posedge clk_i);
            #1;
        end
    endtask

    initial begin
        // Test 1: period 4 after preload via uev
        add(0,0,3,1, 0,0,0); add(0,1,3,1, 0,0,0);
        add(1,0,3,1, 0,0,3); add(1,0,3,1, 0,1,3); add(1,0,3,1, 0,2,3); add(1,0,3,1, 1,3,3);
        add(1,0,3,1, 0,0,3);
        // Test 2: psc change without uev is ignored; uev at cnt 2 switches to period 2
        add(1,0,1,1, 0,1,3); add(1,0,1,1, 0,2,3); add(1,0,1,1, 1,3,3); add(1,0,1,1, 0,0,3);
        add(1,0,1,1, 0,1,3); add(1,1,1,1, 0,2,3);
        add(1,0,1,1, 0,0,1); add(1,0,1,1, 1,1,1); add(1,0,1,1, 0,0,1); add(1,0,1,1, 1,1,1);
        // Test 3: immediate reload, divisor shrinks below count
        add(1,0,9,0, 0,0,1); add(1,0,9,0, 0,1,9); add(1,0,9,0, 0,2,9); add(1,0,9,0, 0,3,9);
        add(1,0,9,0, 0,4,9); add(0,0,2,0, 0,5,9); add(1,0,2,0, 1,5,2);
        add(1,0,2,0, 0,0,2); add(1,0,2,0, 0,1,2); add(1,0,2,0, 1,2,2); add(1,0,2,0, 0,0,2);
        // Test 4: divisor 0 ticks every cycle; cen_i gates it
        add(1,0,0,0, 0,1,2); add(1,0,0,0, 1,2,0); add(1,0,0,0, 1,0,0); add(1,0,0,0, 1,0,0);
        add(0,0,0,0, 0,0,0); add(0,0,0,0, 0,0,0); add(0,0,0,0, 0,0,0);
        add(1,0,0,0, 1,0,0); add(1,0,0,0, 1,0,0);

        // Reset with cen_i high: tick_o must still be gated low
        aresetn_i = 1'b0;
        cen_i     = 1'b1;
        uev_i     = 1'b0;
        psc_i     = '0;
        ppe_i     = 1'b1;
        src_sel_i = 1'b0;
        etr_i     = 1'b0;
        etr_pol_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst.tick", 32'(tick_o), 32'd0);
        chk("rst.cnt", 32'(cnt_o), 32'd0);
        chk("rst.sh", 32'(psc_shadow_o), 32'd0);
        cen_i     = 1'b0;
        aresetn_i = 1'b1;

        foreach (vecs[i]) begin
            cen_i = vecs[i].cen;
            uev_i = vecs[i].uev;
            psc_i = vecs[i].psc;
            ppe_i = vecs[i].ppe;
            cyc($sformatf("vec%0d", i), vecs[i].tick, 32'(vecs[i].cnt), 32'(vecs[i].sh));
        end

        // Test 5: external rising edges, shadow 1
        cen_i = 1'b0; psc_i = PSC_WIDTH'(1); ppe_i = 1'b0; src_sel_i = 1'b1;
        cyc("t5.prep", 1'b0, 0, 0);
        cen_i = 1'b1;
        run_etr("t5.rise", SYNC_STAGES);
        etr_i = 1'b0;
        repeat (2) cyc("t5.idle", 1'b0, 0, 1);
        etr_pol_i = 1'b1;
        repeat (4) cyc("t5.poltog", 1'b0, 0, 1);
        run_etr("t5.fall", 4 + SYNC_STAGES);

        // Test 6: async reset mid-count
        etr_i = 1'b0; etr_pol_i = 1'b0; src_sel_i = 1'b0;
        ppe_i = 1'b1; psc_i = PSC_WIDTH'(3); uev_i = 1'b1; cen_i = 1'b0;
        cyc("t6.load", 1'b0, 0, 1);
        uev_i = 1'b0; cen_i = 1'b1;
        cyc("t6.c0", 1'b0, 0, 3);
        cyc("t6.c1", 1'b0, 1, 3);
        chk("t6.pre.cnt", 32'(cnt_o), 32'd2);
        aresetn_i = 1'b0;
        #1;
        chk("t6.rst.cnt", 32'(cnt_o), 32'd0);
        chk("t6.rst.sh", 32'(psc_shadow_o), 32'd0);
        chk("t6.rst.tick", 32'(tick_o), 32'd0);
        @(posedge clk_i);
        #1;
        chk("t6.rsthold.tick", 32'(tick_o), 32'd0);
        aresetn_i = 1'b1;
        #1;
        chk("t6.rel.tick", 32'(tick_o), 32'd1);
        cyc("t6.div0a", 1'b1, 0, 0);
        cyc("t6.div0b", 1'b1, 0, 0);
        uev_i = 1'b1;
        cyc("t6.uev", 1'b0, 0, 0);
        uev_i = 1'b0;
        cyc("t6.p0", 1'b0, 0, 3);
        cyc("t6.p1", 1'b0, 1, 3);
        cyc("t6.p2", 1'b0, 2, 3);
        // Update on the wrap cycle clears without a tick
        uev_i = 1'b1;
        cyc("t6.uevwrap", 1'b0, 3, 3);
        uev_i = 1'b0;
        cyc("t6.after", 1'b0, 0, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
